// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the memory stage (master)
// and the data-memory responder (slave).
//   req_i/we_i/addr_i/wdata_i : request, held stable by the master until resp_valid_o
//   ready_o                   : responder idle, a request will be accepted
//   stall_o                   : hold MEM while a request is outstanding
//   resp_valid_o              : one-cycle completion pulse
//   rdata_o/err_o             : read data and misalignment flag, qualified by resp_valid_o
interface dmem_responder_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        stall_o;
  logic        resp_valid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ready_o, stall_o, resp_valid_o, rdata_o, err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ready_o, stall_o, resp_valid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word data memory behind the MEM stage.
// One request at a time; response pulses LATENCY cycles after accept, then one
// idle cycle before the next accept.
//   clk   : clock, rising edge
//   reset : synchronous, active-high; abandons any outstanding access
//   bus   : dmem_responder_if.slave (request in, ready/stall/response out)
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  // count holds at most LATENCY-1
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                mis_q, mis_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rv_q, rv_d;

  logic [31:0]         mem_q [DEPTH_WORDS];

  // Access strobe and the request fields it acts on: live inputs when the
  // access happens on the accept edge (LATENCY == 1), latched fields otherwise.
  logic                access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;
  logic                acc_mis;
  logic                ready;

  // Address bits above the word index alias; they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr_i[31:ADDR_W+2];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    rv_d      = 1'b0;
    access    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_mis   = mis_q;
    ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[ADDR_W+1:2];
          wdata_d = bus.wdata_i;
          mis_d   = |bus.addr_i[1:0];
          count_d = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = S_BUSY;
          end else begin
            access    = 1'b1;
            acc_we    = bus.we_i;
            acc_idx   = bus.addr_i[ADDR_W+1:2];
            acc_wdata = bus.wdata_i;
            acc_mis   = |bus.addr_i[1:0];
            state_d   = S_RESP;
          end
        end
      end
      S_BUSY: begin
        count_d = count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (access) begin
      rv_d  = 1'b1;
      err_d = acc_mis;
      if (acc_mis)      rdata_d = 32'h0;
      else if (!acc_we) rdata_d = mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // Storage is not reset, but a reset edge must still suppress the write.
  always_ff @(posedge clk) begin
    if (!reset && access && acc_we && !acc_mis)
      mem_q[acc_idx] <= acc_wdata;
  end

  assign bus.ready_o      = ready;
  assign bus.resp_valid_o = rv_q;
  assign bus.stall_o      = bus.req_i & ~rv_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.err_o        = err_q;
endmodule
